// File: rtl/claa_serial_adder_ctrl_pkg.sv
// Shared definitions for the digit-serial CLA add/subtract controller.
package claa_serial_adder_ctrl_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/claa_serial_adder_ctrl_claa4.sv
// 4-bit carry-look-ahead adder slice; all carries come from generate/propagate
// terms so the nibble path is two logic levels past the p/g stage.
module simple_claa_4bit
  import claa_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] s,
  output logic              cout
);

  logic [NIBBLE-1:0] g;
  logic [NIBBLE-1:0] p;
  logic [NIBBLE-1:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c;
  end

endmodule

// File: rtl/claa_serial_adder_ctrl.sv
// Digit-serial WIDTH-bit add/subtract: one nibble per cycle through a single
// CLA slice, carry held in a register between steps. WIDTH: multiple of 4, >= 8.
module claa_serial_adder_ctrl
  import claa_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / NIBBLE;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [NIBBLE-1:0] slice_s;
  logic              slice_cout;
  logic              accept;

  simple_claa_4bit u_slice (
    .a    (a_sh_q[NIBBLE-1:0]),
    .b    (b_sh_q[NIBBLE-1:0]),
    .cin  (c_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    ready    = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready  = 1'b1;
        accept = start;
      end
      ST_RUN: begin
        // Result assembles LSB-first from the top, so after N steps it is aligned.
        sum_sh_d = {slice_s, sum_sh_q[WIDTH-1:NIBBLE]};
        a_sh_d   = a_sh_q >> NIBBLE;
        b_sh_d   = b_sh_q >> NIBBLE;
        c_d      = slice_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        ready   = 1'b1;
        done    = 1'b1;
        accept  = start;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Subtract as a + ~b + 1: invert b once at latch time, seed the carry with 1.
    if (accept) begin
      state_d = ST_RUN;
      a_sh_d  = a;
      b_sh_d  = sub ? ~b : b;
      c_d     = sub;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sum  = sum_sh_q;
  assign cout = c_q;

endmodule
